// File: rtl/hbm_fetch_pkg.sv
// Shared types and constants for the host->card fetch path and its write-back counterpart.
package hbm_fetch_pkg;

    localparam int unsigned BEAT_BYTES = 64;
    localparam int unsigned BEAT_SHIFT = 6;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_CMD   = 2'd1,
        FETCH_RECV  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_t;

    // One read-data FIFO entry: 512b beat plus end-of-transfer marker.
    typedef struct packed {
        logic         last;
        logic [511:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/hbm_fetch_x_if.sv
// DMA command and 512b data stream bundles used by the fetch engine.
interface axis_mem_cmd;
    logic        valid;
    logic        ready;
    logic [63:0] address;
    logic [31:0] length;

    modport master (output valid, output address, output length, input ready);
    modport slave  (input valid, input address, input length, output ready);
endinterface

interface axi_stream;
    logic         valid;
    logic         ready;
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is visible whenever empty_o is low.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 513,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push      = wr_en_i & ~full_o;
    assign pop       = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset flushes the contents.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write; no reset needed since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/hbm_fetch_x.sv
// Host->card DMA read engine: splits a transfer into boundary-safe read commands, buffers the
// returned beats and streams them to the HBM/SGD consumer.
module hbm_fetch_x
    import hbm_fetch_pkg::*;
#(
    parameter int unsigned MAX_CMD_BYTES = 4096,
    parameter int unsigned FIFO_DEPTH    = 64
) (
    input  logic          hbm_clk,
    input  logic          hbm_areset,
    axis_mem_cmd.master   m_axis_dma_read_cmd,
    axi_stream.slave      s_axis_dma_read_data,
    input  logic          start,
    input  logic [63:0]   addr_x,
    input  logic [31:0]   data_length,
    output logic [511:0]  m_fetch_data,
    output logic          m_fetch_valid,
    input  logic          m_fetch_ready,
    output logic          m_fetch_last,
    output logic          busy,
    output logic          done,
    output logic          err_last
);

    localparam logic [1:0] StIdle  = FETCH_IDLE;
    localparam logic [1:0] StCmd   = FETCH_CMD;
    localparam logic [1:0] StRecv  = FETCH_RECV;
    localparam logic [1:0] StDrain = FETCH_DRAIN;

    localparam int unsigned BeatW    = $clog2(MAX_CMD_BYTES / BEAT_BYTES) + 1;
    localparam logic [63:0] OffsMask = 64'(MAX_CMD_BYTES - 1);

    logic [1:0]       state_q, state_d;
    logic [63:0]      addr_q, addr_d;
    logic [32:0]      rem_q, rem_d;
    logic [32:0]      chunk_q, chunk_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic        cmd_hs, data_hs, fetch_pop, last_flag;
    logic        fifo_full, fifo_empty, s_ready;
    logic [63:0] addr_start;
    logic [32:0] rem_start;
    fifo_entry_t wr_entry, rd_entry;
    logic        unused_bits;

    // Largest chunk that neither exceeds the remainder nor crosses a command-size boundary.
    function automatic logic [32:0] chunk_of(input logic [63:0] a, input logic [32:0] r);
        logic [32:0] room;
        room = 33'(MAX_CMD_BYTES) - 33'(a & OffsMask);
        return (r < room) ? r : room;
    endfunction

    assign addr_start = {addr_x[63:6], 6'b0};
    // 33b so lengths near 4 GiB round up without wrapping.
    assign rem_start  = ({1'b0, data_length} + 33'd63) & ~33'd63;

    assign s_ready   = ~fifo_full & (state_q == StRecv);
    assign cmd_hs    = cmd_valid_q & m_axis_dma_read_cmd.ready;
    assign data_hs   = s_axis_dma_read_data.valid & s_ready;
    assign fetch_pop = m_fetch_valid & m_fetch_ready;
    assign last_flag = (beat_q == BeatW'(1)) && (rem_q == '0);

    assign wr_entry.last = last_flag;
    assign wr_entry.data = s_axis_dma_read_data.data;

    assign unused_bits = ^{addr_x[5:0], s_axis_dma_read_data.keep};

    // Next-state decode for the command/receive/drain sequence.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        chunk_d     = chunk_q;
        beat_d      = beat_q;
        cmd_valid_d = cmd_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d = addr_start;
                    rem_d  = rem_start;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (rem_start == '0) begin
                        state_d = StDrain;
                    end else begin
                        state_d     = StCmd;
                        chunk_d     = chunk_of(addr_start, rem_start);
                        cmd_valid_d = 1'b1;
                    end
                end
            end
            StCmd: begin
                if (cmd_hs) begin
                    cmd_valid_d = 1'b0;
                    beat_d      = chunk_q[BEAT_SHIFT +: BeatW];
                    addr_d      = addr_q + {31'b0, chunk_q};
                    rem_d       = rem_q - chunk_q;
                    state_d     = StRecv;
                end
            end
            StRecv: begin
                if (data_hs) begin
                    beat_d = beat_q - BeatW'(1);
                    if (s_axis_dma_read_data.last != (beat_q == BeatW'(1))) err_d = 1'b1;
                    if (beat_q == BeatW'(1)) begin
                        if (rem_q != '0) begin
                            state_d     = StCmd;
                            chunk_d     = chunk_of(addr_q, rem_q);
                            cmd_valid_d = 1'b1;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                // The last-flagged entry is always the final one, so popping it empties the FIFO.
                if (fifo_empty || (fetch_pop && rd_entry.last)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any transfer in flight.
    always_ff @(posedge hbm_clk or posedge hbm_areset) begin
        if (hbm_areset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            beat_q      <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            chunk_q     <= chunk_d;
            beat_q      <= beat_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (hbm_clk),
        .rst_i     (hbm_areset),
        .wr_en_i   (data_hs),
        .wr_data_i (wr_entry),
        .full_o    (fifo_full),
        .rd_en_i   (m_fetch_ready),
        .rd_data_o (rd_entry),
        .empty_o   (fifo_empty)
    );

    assign m_axis_dma_read_cmd.valid   = cmd_valid_q;
    assign m_axis_dma_read_cmd.address = addr_q;
    assign m_axis_dma_read_cmd.length  = chunk_q[31:0];
    assign s_axis_dma_read_data.ready  = s_ready;

    assign m_fetch_valid = ~fifo_empty;
    assign m_fetch_data  = rd_entry.data;
    assign m_fetch_last  = rd_entry.last & ~fifo_empty;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_last      = err_q;

endmodule

// File: tb/tb_hbm_fetch_x.sv
// Directed bench for hbm_fetch_x with a host model and cmd/beat scoreboards.
module tb_hbm_fetch_x;
    import hbm_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start;
    logic [63:0]  addr_x;
    logic [31:0]  dlen;
    logic [511:0] f_data;
    logic         f_valid, f_ready, f_last, busy, done, err_last;

    axis_mem_cmd cmd_if ();
    axi_stream   dat_if ();

    always #5 clk = ~clk;

    hbm_fetch_x #(
        .MAX_CMD_BYTES (4096),
        .FIFO_DEPTH    (64)
    ) dut (
        .hbm_clk              (clk),
        .hbm_areset           (rst),
        .m_axis_dma_read_cmd  (cmd_if),
        .s_axis_dma_read_data (dat_if),
        .start                (start),
        .addr_x               (addr_x),
        .data_length          (dlen),
        .m_fetch_data         (f_data),
        .m_fetch_valid        (f_valid),
        .m_fetch_ready        (f_ready),
        .m_fetch_last         (f_last),
        .busy                 (busy),
        .done                 (done),
        .err_last             (err_last)
    );

    typedef struct {logic [63:0] a; longint unsigned len;} cmd_t;
    typedef struct {logic last; logic [511:0] data;} beat_t;
    typedef struct {logic [63:0] a; logic last;} hbeat_t;

    cmd_t   exp_cmd [$];
    beat_t  exp_out [$];
    hbeat_t host_q  [$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_in = 0;
    int   last_out_cyc = 0;
    int   bad_last_idx = -1;
    logic pend_din = 1'b0;
    cmd_t  e_c;
    beat_t e_b;
    int    nb;

    assign cmd_if.ready = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] pat(input logic [63:0] a);
        return {8{a ^ 64'h5a5a_0000_0000_0000}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Host model and output monitor; everything is sampled and driven on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            host_q.delete();
            exp_cmd.delete();
            exp_out.delete();
            pend_din     = 1'b0;
            dat_if.valid = 1'b0;
            dat_if.last  = 1'b0;
            dat_if.data  = '0;
            dat_if.keep  = '1;
        end else begin
            if (pend_din) begin
                void'(host_q.pop_front());
                n_in++;
            end
            if (host_q.size() > 0) begin
                dat_if.valid = 1'b1;
                dat_if.data  = pat(host_q[0].a);
                dat_if.last  = host_q[0].last;
            end else begin
                dat_if.valid = 1'b0;
                dat_if.last  = 1'b0;
            end
            if (cmd_if.valid && cmd_if.ready) begin
                chk("cmd_pending", 512'(exp_cmd.size() != 0), 512'(1));
                if (exp_cmd.size() != 0) begin
                    e_c = exp_cmd.pop_front();
                    chk("cmd_addr", cmd_if.address, e_c.a);
                    chk("cmd_len", cmd_if.length, e_c.len);
                end
                nb = int'(cmd_if.length / 64);
                for (int i = 0; i < nb; i++) begin
                    host_q.push_back('{a: cmd_if.address + 64'(64 * i),
                                       last: (bad_last_idx >= 0) ? (i == bad_last_idx)
                                                                 : (i == nb - 1)});
                end
            end
            pend_din = dat_if.valid && dat_if.ready;
            if (f_valid && f_ready) begin
                chk("out_pending", 512'(exp_out.size() != 0), 512'(1));
                if (exp_out.size() != 0) begin
                    e_b = exp_out.pop_front();
                    chk("out_data", f_data, e_b.data);
                    chk("out_last", f_last, e_b.last);
                end
                last_out_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Builds the expected command and beat sequence, then pulses start.
    task automatic xfer(input logic [63:0] a_in, input logic [31:0] len, output int s_cyc);
        logic [63:0]     a;
        longint unsigned rem, room, ch;
        a   = {a_in[63:6], 6'b0};
        rem = (64'(len) + 64'd63) & ~64'd63;
        while (rem > 0) begin
            room = 64'd4096 - (a % 64'd4096);
            ch   = (rem < room) ? rem : room;
            exp_cmd.push_back('{a: a, len: ch});
            for (longint unsigned i = 0; i < ch / 64; i++) begin
                exp_out.push_back('{last: (rem == ch) && (i == ch / 64 - 1),
                                    data: pat(a + 64 * i)});
            end
            a   = a + ch;
            rem = rem - ch;
        end
        start  = 1'b1;
        addr_x = a_in;
        dlen   = len;
        s_cyc  = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int d_cyc);
        logic got;
        got   = 1'b0;
        d_cyc = -1;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got   = 1'b1;
                d_cyc = cyc;
            end
        end
        chk(tag, got, 1'b1);
        @(negedge clk);
        chk({tag, "_pulse"}, {done, busy}, 2'b00);
        chk({tag, "_cmdq"}, exp_cmd.size(), 0);
        chk({tag, "_outq"}, exp_out.size(), 0);
        tick();
    endtask

    initial begin
        int sc, dc, n0;
        start   = 1'b0;
        addr_x  = '0;
        dlen    = '0;
        f_ready = 1'b1;
        rst     = 1'b1;
        repeat (3) tick();
        chk("rst_outs", {busy, done, err_last, cmd_if.valid, dat_if.ready, f_valid, f_last}, 7'b0);
        rst = 1'b0;
        repeat (2) tick();

        // Aligned single command, done the cycle after the final pop.
        xfer(64'h1000, 32'd256, sc);
        chk("busy_after_start", busy, 1'b1);
        wait_done("done_256", 200, dc);
        chk("done_latency", dc, last_out_cyc + 1);
        chk("err_256", err_last, 1'b0);

        // Crosses a 4 KiB boundary: split into two commands.
        xfer(64'h0FC0, 32'd192, sc);
        wait_done("done_split", 200, dc);
        chk("err_split", err_last, 1'b0);

        // Unaligned length rounds up; unaligned address is truncated.
        xfer(64'h5007, 32'd100, sc);
        wait_done("done_len100", 200, dc);

        // Zero length: no command, done two cycles after start is driven.
        xfer(64'h8000, 32'd0, sc);
        wait_done("done_len0", 20, dc);
        chk("len0_latency", dc - sc, 2);

        // Consumer stalled: FIFO fills, input backpressures, then drains without loss.
        f_ready = 1'b0;
        n0 = n_in;
        xfer(64'h10000, 32'd8192, sc);
        repeat (200) tick();
        chk("bp_beats_in", n_in - n0, 64);
        chk("bp_s_ready", dat_if.ready, 1'b0);
        chk("bp_f_valid", f_valid, 1'b1);
        f_ready = 1'b1;
        wait_done("done_bp", 1000, dc);

        // Early tlast from the host flags err_last but all beats still flow.
        bad_last_idx = 1;
        xfer(64'h6000, 32'd256, sc);
        wait_done("done_err", 200, dc);
        chk("err_set", err_last, 1'b1);
        bad_last_idx = -1;
        xfer(64'h7000, 32'd64, sc);
        chk("err_cleared", err_last, 1'b0);
        wait_done("done_after_err", 200, dc);

        // Reset while receiving aborts immediately.
        n0 = n_in;
        xfer(64'h4000, 32'd1024, sc);
        for (int i = 0; i < 100 && (n_in - n0) < 3; i++) tick();
        chk("reached_recv", 512'((n_in - n0) >= 3), 512'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {busy, done, err_last, cmd_if.valid, dat_if.ready, f_valid, f_last},
            7'b0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Post-reset transfer; a second start while busy must be ignored.
        xfer(64'h2000, 32'd64, sc);
        start  = 1'b1;
        addr_x = 64'h9000;
        dlen   = 32'd128;
        tick();
        start = 1'b0;
        chk("busy_held", busy, 1'b1);
        wait_done("done_post_rst", 200, dc);
        repeat (20) tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_outq", exp_out.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
